debounce_bank: RTL and testbench
================================

DEBOUNCE_BANK -- requirements
Module: debounce_bank

Interface
REQ-001 Parameter CHANNELS, 4, number of independent debounced inputs (1..32).
REQ-002 Parameter STABLE_CYCLES, 30000000, consecutive synchronized cycles an input must hold a new level before it is accepted (>=1).
REQ-003 Parameter SYNC_STAGES, 2, synchronizer flops per channel (>=2).
REQ-004 Parameter ACTIVE_LOW, 0, 1 means a raw input of 0 is "pressed".
REQ-005 Parameter REPEAT_EN, 0, 1 enables auto-repeat pulses while held.
REQ-006 Parameter REPEAT_DELAY, 15000000, cycles from press_pulse to first repeat_pulse (>=1).
REQ-007 Parameter REPEAT_RATE, 5000000, cycles between subsequent repeat_pulses (>=1).
REQ-008 clock  input  1  rising-edge system clock.
REQ-009 reset  input  1  asynchronous, active-high reset.
REQ-010 raw_in  input  CHANNELS  asynchronous button/contact inputs.
REQ-011 level  output  CHANNELS  debounced state, 1 = pressed.
REQ-012 press_pulse  output  CHANNELS  one-cycle pulse on accepted press.
REQ-013 release_pulse  output  CHANNELS  one-cycle pulse on accepted release.
REQ-014 repeat_pulse  output  CHANNELS  one-cycle auto-repeat pulse; constant 0 when REPEAT_EN=0.
REQ-015 any_press  output  1  OR of press_pulse, same cycle.

Function
REQ-016 Each channel SHALL pass raw_in through SYNC_STAGES flops, then apply ACTIVE_LOW inversion; all later logic uses this synchronized value s.
REQ-017 Per channel, stable counter SHALL increment each cycle s differs from level and clear to 0 in any cycle s equals level.
REQ-018 When counter equals STABLE_CYCLES-1 and s still differs, next edge SHALL set level to s, clear counter, and assert press_pulse (s=1) or release_pulse (s=0) for exactly one cycle.
REQ-019 Latency: a clean raw edge SHALL appear on level and the pulse exactly SYNC_STAGES+STABLE_CYCLES edges after first sampling.
REQ-020 Any excursion of s shorter than STABLE_CYCLES SHALL produce no level change and no pulse; counter restarts from 0 on each bounce.
REQ-021 Counter width SHALL be clog2(STABLE_CYCLES+1); the counter SHALL never wrap or exceed STABLE_CYCLES-1.
REQ-022 Per-channel FSM states: RELEASED, PRESS_PENDING (counting toward press), HELD, RELEASE_PENDING; PENDING returns to prior stable state when s reverts.
REQ-023 With REPEAT_EN=1, repeat counter SHALL start at press acceptance, emit repeat_pulse REPEAT_DELAY cycles after press_pulse, then every REPEAT_RATE cycles while level=1.
REQ-024 Repeat counter SHALL clear on release acceptance and in RELEASE_PENDING; no repeat_pulse SHALL coincide with press_pulse or release_pulse.
REQ-025 Channels SHALL be fully independent; simultaneous events on several channels SHALL each pulse in the same cycle.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 reset SHALL asynchronously force level, all pulses, any_press, all counters to 0, FSMs to RELEASED, and synchronizer flops to the unpressed raw value.
REQ-028 Reset mid-count SHALL discard partial progress; after release of reset a full SYNC_STAGES+STABLE_CYCLES is required for acceptance.

Structure
REQ-029 State encodings and a clog2 constant function SHALL live in shared package debounce_pkg.
REQ-030 Per-channel logic SHALL be sub-module debounce_channel, instantiated CHANNELS times by generate; top holds only any_press.

Verification (CHANNELS=4, STABLE_CYCLES=8, SYNC_STAGES=2, REPEAT_EN=1, REPEAT_DELAY=20, REPEAT_RATE=5)
REQ-031 raw_in[0] 0->1 sampled edge 1, held -> press_pulse[0] and any_press high one cycle at edge 10, level[0]=1 thereafter.
REQ-032 raw_in[2] high 7 cycles then low -> no pulse, level[2]=0; high 8 cycles -> press_pulse[2] once.
REQ-033 raw_in[1] toggling every 3 cycles for 30 cycles then steady high -> exactly one press_pulse[1], 10 edges after last toggle.
REQ-034 Hold ch0 60 cycles past press -> repeat_pulse[0] at press+20,+25,+30...; release -> one release_pulse[0], no further repeats.
REQ-035 reset asserted after 5 stable cycles on ch3 -> all outputs 0 immediately; after deassert, press_pulse[3] only 10 edges later.
REQ-036 raw_in[1] and raw_in[3] rise same cycle -> both press_pulses same cycle, any_press high exactly one cycle.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared definitions for the debounce bank.
//   db_state_t : per-channel debounce FSM states
//   clog2      : constant function sizing the stable and repeat counters
package debounce_pkg;

  typedef enum logic [1:0] {
    RELEASED        = 2'd0,
    PRESS_PENDING   = 2'd1,
    HELD            = 2'd2,
    RELEASE_PENDING = 2'd3
  } db_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    longint unsigned v;
    int unsigned     r;
    v = 64'd1;
    r = 0;
    while (v < 64'(value)) begin
      v = v << 1;
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input channel: synchronizer, stable-count FSM and optional
// auto-repeat generator.
// Ports:
//   clock, reset    : rising-edge clock, asynchronous active-high reset
//   raw_in          : asynchronous contact input
//   level           : registered debounced state, 1 = pressed
//   press_pulse     : registered one-cycle pulse on accepted press
//   release_pulse   : registered one-cycle pulse on accepted release
//   repeat_pulse    : registered one-cycle auto-repeat pulse
//   press_next      : next-cycle value of press_pulse, lets the parent register
//                     an aggregate that lines up with press_pulse
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 30000000,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ACTIVE_LOW    = 0,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned REPEAT_DELAY  = 15000000,
  parameter int unsigned REPEAT_RATE   = 5000000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic press_next
);

  localparam int unsigned CW   = clog2(STABLE_CYCLES + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int unsigned RW   = clog2(RMAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
  localparam logic          IDLE_RAW   = (ACTIVE_LOW != 0);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  db_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
  logic          rpt_first_q, rpt_first_d;
  logic          level_d, press_d, release_d, repeat_d;
  logic          cnt_hit, rpt_hit;

  // Synchronizer resets to the idle raw level so reset never looks like a press.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{IDLE_RAW}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], raw_in};
    end
  end

  assign s       = sync_q[SYNC_STAGES-1] ^ IDLE_RAW;
  assign cnt_hit = (cnt_q == CNT_LAST);
  assign rpt_hit = rpt_first_q ? (rpt_cnt_q == DELAY_LAST) : (rpt_cnt_q == RATE_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= RELEASED;
      cnt_q         <= '0;
      rpt_cnt_q     <= '0;
      rpt_first_q   <= 1'b1;
      level         <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rpt_cnt_q     <= rpt_cnt_d;
      rpt_first_q   <= rpt_first_d;
      level         <= level_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      repeat_pulse  <= repeat_d;
    end
  end

  // The stable counter clears by default; it only advances while s disagrees
  // with the accepted level, and acceptance happens instead of reaching
  // STABLE_CYCLES, so it cannot wrap.
  always_comb begin
    state_d     = state_q;
    cnt_d       = '0;
    rpt_cnt_d   = rpt_cnt_q;
    rpt_first_d = rpt_first_q;
    level_d     = level;
    press_d     = 1'b0;
    release_d   = 1'b0;
    repeat_d    = 1'b0;

    case (state_q)
      RELEASED, PRESS_PENDING: begin
        rpt_cnt_d   = '0;
        rpt_first_d = 1'b1;
        if (s) begin
          if (cnt_hit) begin
            state_d = HELD;
            level_d = 1'b1;
            press_d = 1'b1;
          end else begin
            state_d = PRESS_PENDING;
            cnt_d   = cnt_q + CW'(1);
          end
        end else begin
          state_d = RELEASED;
        end
      end

      HELD, RELEASE_PENDING: begin
        if (!s) begin
          rpt_cnt_d   = '0;
          rpt_first_d = 1'b1;
          if (cnt_hit) begin
            state_d   = RELEASED;
            level_d   = 1'b0;
            release_d = 1'b1;
          end else begin
            state_d = RELEASE_PENDING;
            cnt_d   = cnt_q + CW'(1);
          end
        end else begin
          state_d = HELD;
          // Repeat timing runs only while s agrees with a pressed level, so a
          // repeat can never land on the press or release pulse cycle.
          if (REPEAT_EN != 0) begin
            if (rpt_hit) begin
              repeat_d    = 1'b1;
              rpt_cnt_d   = '0;
              rpt_first_d = 1'b0;
            end else begin
              rpt_cnt_d = rpt_cnt_q + RW'(1);
            end
          end
        end
      end
    endcase
  end

  assign press_next = press_d;

endmodule

// File: rtl/debounce_bank.sv
// Bank of independent debounced inputs with optional auto-repeat.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   raw_in        : CHANNELS asynchronous button/contact inputs
//   level         : debounced state per channel, 1 = pressed
//   press_pulse   : one-cycle pulse per channel on accepted press
//   release_pulse : one-cycle pulse per channel on accepted release
//   repeat_pulse  : one-cycle auto-repeat pulse per channel (0 if REPEAT_EN=0)
//   any_press     : OR of press_pulse, registered to align with press_pulse
module debounce_bank #(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned STABLE_CYCLES = 30000000,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned ACTIVE_LOW    = 0,
  parameter int unsigned REPEAT_EN     = 0,
  parameter int unsigned REPEAT_DELAY  = 15000000,
  parameter int unsigned REPEAT_RATE   = 5000000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] raw_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic [CHANNELS-1:0] repeat_pulse,
  output logic                any_press
);

  logic [CHANNELS-1:0] press_next;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .SYNC_STAGES   (SYNC_STAGES),
      .ACTIVE_LOW    (ACTIVE_LOW),
      .REPEAT_EN     (REPEAT_EN),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_RATE   (REPEAT_RATE)
    ) u_chan (
      .clock         (clock),
      .reset         (reset),
      .raw_in        (raw_in[i]),
      .level         (level[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .press_next    (press_next[i])
    );
  end

  // Registered from the channels' next-cycle press values so it asserts in
  // the same cycle as the press_pulse bits it summarises.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      any_press <= 1'b0;
    end else begin
      any_press <= |press_next;
    end
  end

endmodule

// File: tb/tb_debounce_bank.sv
module tb_debounce_bank;

  logic       clock;
  logic       reset;
  logic [3:0] raw_in;
  logic [3:0] level;
  logic [3:0] press_pulse;
  logic [3:0] release_pulse;
  logic [3:0] repeat_pulse;
  logic       any_press;

  int n_checks;
  int n_fail;

  debounce_bank #(
    .CHANNELS      (4),
    .STABLE_CYCLES (8),
    .SYNC_STAGES   (2),
    .ACTIVE_LOW    (0),
    .REPEAT_EN     (1),
    .REPEAT_DELAY  (20),
    .REPEAT_RATE   (5)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .raw_in        (raw_in),
    .level         (level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .any_press     (any_press)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    raw_in = 4'b0000;
    tick();
    tick();
    n_checks++; if (level !== 4'b0000) begin n_fail++; $display("FAIL reset_level got=%b exp=0000", level); end
    n_checks++; if (press_pulse !== 4'b0000) begin n_fail++; $display("FAIL reset_press got=%b exp=0000", press_pulse); end
    n_checks++; if (release_pulse !== 4'b0000) begin n_fail++; $display("FAIL reset_release got=%b exp=0000", release_pulse); end
    n_checks++; if (repeat_pulse !== 4'b0000) begin n_fail++; $display("FAIL reset_repeat got=%b exp=0000", repeat_pulse); end
    n_checks++; if (any_press !== 1'b0) begin n_fail++; $display("FAIL reset_any got=%b exp=0", any_press); end
    reset = 1'b0;
    tick();
  endtask

  // ch0 press latency, then auto-repeat cadence while held, then release.
  task automatic test_press_repeat();
    int rel_cnt;
    int rep_cnt;
    raw_in[0] = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      n_checks++; if (press_pulse[0] !== (e == 10)) begin n_fail++; $display("FAIL press0 edge=%0d got=%b exp=%b", e, press_pulse[0], (e == 10)); end
      n_checks++; if (any_press !== (e == 10)) begin n_fail++; $display("FAIL any_press0 edge=%0d got=%b exp=%b", e, any_press, (e == 10)); end
      n_checks++; if (level[0] !== (e >= 10)) begin n_fail++; $display("FAIL level0 edge=%0d got=%b exp=%b", e, level[0], (e >= 10)); end
    end
    for (int off = 1; off <= 60; off++) begin
      tick();
      n_checks++;
      if (repeat_pulse[0] !== (off >= 20 && ((off - 20) % 5) == 0)) begin
        n_fail++;
        $display("FAIL repeat0 offset=%0d got=%b exp=%b", off, repeat_pulse[0], (off >= 20 && ((off - 20) % 5) == 0));
      end
      n_checks++; if (press_pulse[0] !== 1'b0) begin n_fail++; $display("FAIL press0_held offset=%0d got=%b exp=0", off, press_pulse[0]); end
    end
    raw_in[0] = 1'b0;
    rel_cnt = 0;
    rep_cnt = 0;
    for (int e = 1; e <= 30; e++) begin
      tick();
      if (release_pulse[0]) rel_cnt++;
      if (repeat_pulse[0]) rep_cnt++;
      if (e == 10) begin
        n_checks++; if (release_pulse[0] !== 1'b1) begin n_fail++; $display("FAIL release0_edge got=%b exp=1", release_pulse[0]); end
      end
    end
    n_checks++; if (rel_cnt != 1) begin n_fail++; $display("FAIL release0_count got=%0d exp=1", rel_cnt); end
    n_checks++; if (rep_cnt != 0) begin n_fail++; $display("FAIL repeat0_after_release got=%0d exp=0", rep_cnt); end
    n_checks++; if (level[0] !== 1'b0) begin n_fail++; $display("FAIL level0_released got=%b exp=0", level[0]); end
  endtask

  // ch2: 7-cycle glitch rejected, 8-cycle hold accepted once.
  task automatic test_boundary();
    int pc;
    raw_in[2] = 1'b1;
    pc = 0;
    for (int e = 1; e <= 7; e++) begin tick(); if (press_pulse[2]) pc++; end
    raw_in[2] = 1'b0;
    for (int e = 1; e <= 15; e++) begin tick(); if (press_pulse[2] || release_pulse[2]) pc++; end
    n_checks++; if (pc != 0) begin n_fail++; $display("FAIL short7_pulses got=%0d exp=0", pc); end
    n_checks++; if (level[2] !== 1'b0) begin n_fail++; $display("FAIL short7_level got=%b exp=0", level[2]); end
    raw_in[2] = 1'b1;
    pc = 0;
    for (int e = 1; e <= 8; e++) begin tick(); if (press_pulse[2]) pc++; end
    raw_in[2] = 1'b0;
    for (int e = 1; e <= 4; e++) begin tick(); if (press_pulse[2]) pc++; end
    n_checks++; if (pc != 1) begin n_fail++; $display("FAIL hold8_press_count got=%0d exp=1", pc); end
    n_checks++; if (level[2] !== 1'b1) begin n_fail++; $display("FAIL hold8_level got=%b exp=1", level[2]); end
    for (int e = 1; e <= 12; e++) tick();
    n_checks++; if (level[2] !== 1'b0) begin n_fail++; $display("FAIL hold8_release_level got=%b exp=0", level[2]); end
  endtask

  // ch1 bounces every 3 cycles for 30 cycles, then settles high.
  task automatic test_bounce();
    int pc;
    pc = 0;
    for (int seg = 0; seg < 10; seg++) begin
      raw_in[1] = ((seg % 2) == 0);
      for (int c = 0; c < 3; c++) begin tick(); if (press_pulse[1]) pc++; end
    end
    n_checks++; if (pc != 0) begin n_fail++; $display("FAIL bounce_press_during got=%0d exp=0", pc); end
    raw_in[1] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (press_pulse[1]) pc++;
      n_checks++; if (press_pulse[1] !== (e == 10)) begin n_fail++; $display("FAIL bounce_press edge=%0d got=%b exp=%b", e, press_pulse[1], (e == 10)); end
    end
    n_checks++; if (pc != 1) begin n_fail++; $display("FAIL bounce_press_count got=%0d exp=1", pc); end
    raw_in[1] = 1'b0;
    for (int e = 1; e <= 12; e++) tick();
  endtask

  // Reset mid-count on ch3 with ch0 held: async clear, then full latency.
  task automatic test_reset_mid();
    raw_in[0] = 1'b1;
    for (int e = 1; e <= 12; e++) tick();
    raw_in[3] = 1'b1;
    for (int e = 1; e <= 5; e++) tick();
    n_checks++; if (level !== 4'b0001) begin n_fail++; $display("FAIL pre_reset_level got=%b exp=0001", level); end
    raw_in[0] = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (level !== 4'b0000) begin n_fail++; $display("FAIL async_reset_level got=%b exp=0000", level); end
    n_checks++; if ({press_pulse, release_pulse, repeat_pulse, any_press} !== 13'd0) begin n_fail++; $display("FAIL async_reset_pulses got=%b exp=0", {press_pulse, release_pulse, repeat_pulse, any_press}); end
    tick();
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      n_checks++; if (press_pulse !== ((e == 10) ? 4'b1000 : 4'b0000)) begin n_fail++; $display("FAIL post_reset_press edge=%0d got=%b exp=%b", e, press_pulse, ((e == 10) ? 4'b1000 : 4'b0000)); end
      n_checks++; if (level[3] !== (e >= 10)) begin n_fail++; $display("FAIL post_reset_level3 edge=%0d got=%b exp=%b", e, level[3], (e >= 10)); end
    end
    raw_in[3] = 1'b0;
    for (int e = 1; e <= 12; e++) tick();
  endtask

  // ch1 and ch3 rise together: both pulses in one cycle, one any_press.
  task automatic test_simultaneous();
    int ac;
    ac = 0;
    raw_in[1] = 1'b1;
    raw_in[3] = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (any_press) ac++;
      n_checks++; if (press_pulse !== ((e == 10) ? 4'b1010 : 4'b0000)) begin n_fail++; $display("FAIL simul_press edge=%0d got=%b exp=%b", e, press_pulse, ((e == 10) ? 4'b1010 : 4'b0000)); end
      n_checks++; if (any_press !== (e == 10)) begin n_fail++; $display("FAIL simul_any edge=%0d got=%b exp=%b", e, any_press, (e == 10)); end
    end
    n_checks++; if (ac != 1) begin n_fail++; $display("FAIL simul_any_count got=%0d exp=1", ac); end
    n_checks++; if (level !== 4'b1010) begin n_fail++; $display("FAIL simul_level got=%b exp=1010", level); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    raw_in   = 4'b0000;
    test_reset();
    test_press_repeat();
    test_boundary();
    test_bounce();
    test_reset_mid();
    test_simultaneous();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
